// File: rtl/boule_rouge_ctrl_if.sv
// Link between boule_rouge_ctrl and boule_rouge_layer.
// The launch command goes out; the hop strobes and the spawn cube coordinates come back.
interface boule_rouge_ctrl_if;
   logic        e_enable_br;
   logic [6:0]  e_move_br;
   logic [20:0] e_XY0_br;
   logic        done_move;
   logic        done_move_sc;
   logic [20:0] xy_cube2;
   logic [20:0] xy_cube3;

   modport master (
      output e_enable_br, e_move_br, e_XY0_br,
      input  done_move, done_move_sc, xy_cube2, xy_cube3
   );

   modport slave (
      input  e_enable_br, e_move_br, e_XY0_br,
      output done_move, done_move_sc, xy_cube2, xy_cube3
   );
endinterface

// File: rtl/boule_rouge_ctrl.sv
// Red-ball sequencer: spawn timing, LFSR hop pattern and side, and one-hot pyramid tracking.
// Optional collision pulse on hit_qb is compiled in with `define BOULE_ROUGE_HIT_EN.
module boule_rouge_ctrl #(
   parameter logic [31:0] SPAWN_DELAY = 32'd50_000_000,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               e_start_qb,
   input  logic               e_pause_qb,
   input  logic               e_resume_qb,
   input  logic [31:0]        qbert_position,
   boule_rouge_ctrl_if.master layer,
   output logic [31:0]        position_br,
   output logic               br_active,
   output logic               hit_qb
);
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LAUNCH, ST_ACTIVE, ST_PAUSED} state_t;

   localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   state_t      state, state_d, ret_state, ret_d;
   logic [31:0] delay_cnt, cnt_d;
   logic [2:0]  hop_cnt, hop_d;
   logic [2:0]  row, row_d;
   logic [15:0] lfsr, lfsr_d, lfsr_step;
   logic        side, side_d;
   logic        dm_q, dm_rise;
   logic [31:0] pos_d;
   logic        en_d;
   logic [6:0]  move_d;
   logic [20:0] xy_d;
   logic [7:0]  move_ext;
   logic        move_bit;
   logic [3:0]  shamt;

   assign dm_rise   = layer.done_move & ~dm_q;
   assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
   // Padding keeps the hop-count index in range; hop 0 never consumes a move bit.
   assign move_ext  = {1'b0, layer.e_move_br};
   assign move_bit  = move_ext[hop_cnt - 3'd1];
   assign shamt     = {1'b0, row} + {3'b000, move_bit};

   always_comb begin
      state_d = state;
      ret_d   = ret_state;
      cnt_d   = delay_cnt;
      hop_d   = hop_cnt;
      row_d   = row;
      side_d  = side;
      pos_d   = position_br;
      en_d    = 1'b0;
      move_d  = layer.e_move_br;
      xy_d    = layer.e_XY0_br;
      lfsr_d  = (state == ST_WAIT || state == ST_LAUNCH || state == ST_ACTIVE) ? lfsr_step : lfsr;

      if (state == ST_IDLE) begin
         if (e_start_qb) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            hop_d   = '0;
         end
      end else if (e_start_qb) begin
         state_d = ST_WAIT;
         pos_d   = '0;
         cnt_d   = '0;
         hop_d   = '0;
      end else if (layer.done_move_sc && (state == ST_LAUNCH || state == ST_ACTIVE)) begin
         state_d = ST_WAIT;
         pos_d   = '0;
         cnt_d   = '0;
         hop_d   = '0;
      end else if (e_pause_qb) begin
         if (state != ST_PAUSED) ret_d = state;
         state_d = ST_PAUSED;
      end else begin
         case (state)
            ST_PAUSED: begin
               if (e_resume_qb) state_d = ret_state;
            end
            ST_WAIT: begin
               if (delay_cnt + 32'd1 >= SPAWN_DELAY) state_d = ST_LAUNCH;
               else cnt_d = delay_cnt + 32'd1;
            end
            ST_LAUNCH: begin
               en_d    = 1'b1;
               move_d  = lfsr[6:0];
               side_d  = lfsr[7];
               xy_d    = lfsr[7] ? layer.xy_cube3 : layer.xy_cube2;
               pos_d   = '0;
               hop_d   = '0;
               state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (dm_rise) begin
                  if (hop_cnt == 3'd0) begin
                     pos_d = side ? 32'h0000_0004 : 32'h0000_0002;
                     row_d = 3'd2;
                     hop_d = 3'd1;
                  end else if (hop_cnt == 3'd6) begin
                     pos_d   = '0;
                     hop_d   = '0;
                     cnt_d   = '0;
                     state_d = ST_WAIT;
                  end else begin
                     hop_d = hop_cnt + 3'd1;
                     if (row == 3'd7) begin
                        pos_d = '0;
                     end else begin
                        pos_d = position_br << shamt;
                        row_d = row + 3'd1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= ST_IDLE;
         ret_state         <= ST_IDLE;
         delay_cnt         <= '0;
         hop_cnt           <= '0;
         row               <= '0;
         lfsr              <= SEED;
         side              <= 1'b0;
         dm_q              <= 1'b0;
         position_br       <= '0;
         layer.e_enable_br <= 1'b0;
         layer.e_move_br   <= '0;
         layer.e_XY0_br    <= '0;
      end else begin
         state             <= state_d;
         ret_state         <= ret_d;
         delay_cnt         <= cnt_d;
         hop_cnt           <= hop_d;
         row               <= row_d;
         lfsr              <= lfsr_d;
         side              <= side_d;
         dm_q              <= layer.done_move;
         position_br       <= pos_d;
         layer.e_enable_br <= en_d;
         layer.e_move_br   <= move_d;
         layer.e_XY0_br    <= xy_d;
      end
   end

   assign br_active = (state == ST_ACTIVE) || (state == ST_PAUSED && ret_state == ST_ACTIVE);

`ifdef BOULE_ROUGE_HIT_EN
   logic hit_cond, hit_cond_q;

   assign hit_cond = (state == ST_ACTIVE) && (|(position_br & qbert_position));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_cond_q <= 1'b0;
         hit_qb     <= 1'b0;
      end else begin
         hit_cond_q <= hit_cond;
         hit_qb     <= hit_cond & ~hit_cond_q;
      end
   end
`else
   logic unused_qbert;

   assign unused_qbert = ^qbert_position;
   assign hit_qb       = 1'b0;
`endif
endmodule

// File: tb/tb_boule_rouge_ctrl.sv
// Bench for boule_rouge_ctrl: directed stimulus, a pyramid-geometry model checked every cycle,
// and hand-computed literals that pin both the model and the DUT.
module tb_boule_rouge_ctrl;
   localparam logic [20:0] XY2 = {11'd300, 10'd100};
   localparam logic [20:0] XY3 = {11'd340, 10'd100};
   localparam int P_IDLE = 0, P_WAIT = 1, P_LAUNCH = 2, P_ACTIVE = 3, P_PAUSED = 4;
   localparam int DELAY = 4;
`ifdef BOULE_ROUGE_HIT_EN
   localparam bit HIT_ON = 1'b1;
`else
   localparam bit HIT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start, pause, resume;
   logic [31:0] qpos;
   logic [31:0] position_br;
   logic        br_active, hit_qb;

   boule_rouge_ctrl_if ifc ();

   boule_rouge_ctrl #(
      .SPAWN_DELAY(32'd4),
      .LFSR_SEED  (16'hACE1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .e_start_qb    (start),
      .e_pause_qb    (pause),
      .e_resume_qb   (resume),
      .qbert_position(qpos),
      .layer         (ifc.master),
      .position_br   (position_br),
      .br_active     (br_active),
      .hit_qb        (hit_qb)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int hit_cnt = 0;
   bit chk_on = 1'b0;

   // Model state, written at the rising edge and read at the falling edge.
   int          m_phase, m_ret, m_cnt, m_hops;
   logic [15:0] m_lfsr;
   bit          m_side, m_en, m_hit, m_cond_prev, m_dm_prev;
   logic [6:0]  m_moves;
   logic [20:0] m_xy;
   logic [31:0] m_pos;

   logic [31:0] pin0 [6] = '{32'h2, 32'h8, 32'h40, 32'h400, 32'h8000, 32'h200000};
   logic [31:0] pin1 [6] = '{32'h4, 32'h20, 32'h200, 32'h4000, 32'h100000, 32'h8000000};
   logic [31:0] lit1 [6] = '{32'h2, 32'h8, 32'h80, 32'h1000, 32'h40000, 32'h1000000};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   // Cube reached after landing number k: rows numbered from 1 at the apex, col counts right hops.
   function automatic logic [31:0] cube(input bit s, input logic [6:0] mv, input int k);
      int row, col;
      row = 2 + k;
      col = int'(s);
      for (int i = 0; i < k; i++) col += int'(mv[i]);
      return 32'h1 << (row * (row - 1) / 2 + col);
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_ret = P_IDLE; m_cnt = 0; m_hops = 0;
      m_lfsr = 16'hACE1; m_side = 1'b0; m_en = 1'b0; m_hit = 1'b0;
      m_cond_prev = 1'b0; m_dm_prev = 1'b0; m_moves = '0; m_xy = '0; m_pos = '0;
   endtask

   task automatic model_step();
      bit rise, cond, adv;
      logic [15:0] lf;
      rise = ifc.done_move && !m_dm_prev;
      m_dm_prev = ifc.done_move;
      cond = (m_phase == P_ACTIVE) && ((m_pos & qpos) != 0);
      m_hit = HIT_ON && cond && !m_cond_prev;
      m_cond_prev = cond;
      m_en = 1'b0;
      adv = (m_phase == P_WAIT) || (m_phase == P_LAUNCH) || (m_phase == P_ACTIVE);
      lf = m_lfsr;
      if (m_phase == P_IDLE) begin
         if (start) begin m_phase = P_WAIT; m_cnt = 0; m_hops = 0; end
      end else if (start || (ifc.done_move_sc && (m_phase == P_LAUNCH || m_phase == P_ACTIVE))) begin
         m_phase = P_WAIT; m_pos = '0; m_cnt = 0; m_hops = 0;
      end else if (pause) begin
         if (m_phase != P_PAUSED) m_ret = m_phase;
         m_phase = P_PAUSED;
      end else if (m_phase == P_PAUSED) begin
         if (resume) m_phase = m_ret;
      end else if (m_phase == P_WAIT) begin
         if (m_cnt == DELAY - 1) m_phase = P_LAUNCH;
         else m_cnt++;
      end else if (m_phase == P_LAUNCH) begin
         m_en = 1'b1; m_moves = lf[6:0]; m_side = lf[7];
         m_xy = lf[7] ? XY3 : XY2; m_pos = '0; m_hops = 0; m_phase = P_ACTIVE;
      end else if (m_phase == P_ACTIVE && rise) begin
         if (m_hops == 6) begin
            m_pos = '0; m_hops = 0; m_cnt = 0; m_phase = P_WAIT;
         end else begin
            m_pos = cube(m_side, m_moves, m_hops);
            m_hops++;
         end
      end
      if (adv) m_lfsr = lfsr_next(lf);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("e_enable_br", {31'b0, ifc.e_enable_br}, {31'b0, m_en});
         check("e_move_br", {25'b0, ifc.e_move_br}, {25'b0, m_moves});
         check("e_XY0_br", {11'b0, ifc.e_XY0_br}, {11'b0, m_xy});
         check("position_br", position_br, m_pos);
         check("br_active", {31'b0, br_active},
               {31'b0, (m_phase == P_ACTIVE) || (m_phase == P_PAUSED && m_ret == P_ACTIVE)});
         check("hit_qb", {31'b0, hit_qb}, {31'b0, m_hit});
         if (hit_qb === 1'b1) hit_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic hop();
      ifc.done_move = 1'b1; tick(); tick();
      ifc.done_move = 1'b0; tick(); tick();
   endtask

   task automatic wait_launch(output int k);
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (ifc.e_enable_br === 1'b1) begin
            k = i;
            break;
         end
      end
   endtask

   initial begin
      int k;
      reset = 1'b0; start = 1'b0; pause = 1'b0; resume = 1'b0; qpos = '0;
      ifc.done_move = 1'b0; ifc.done_move_sc = 1'b0;
      ifc.xy_cube2 = XY2; ifc.xy_cube3 = XY3;
      model_reset();

      for (int i = 0; i < 6; i++) begin
         check("pin_side0", cube(1'b0, 7'h00, i), pin0[i]);
         check("pin_side1", cube(1'b1, 7'h3F, i), pin1[i]);
      end
      check("pin_lfsr", {16'b0, lfsr_next(lfsr_next(lfsr_next(lfsr_next(16'hACE1))))}, 32'h1C4E);

      repeat (3) @(negedge clk);
      check("rst_position", position_br, 32'h0);
      check("rst_enable", {31'b0, ifc.e_enable_br}, 32'h0);
      check("rst_move", {25'b0, ifc.e_move_br}, 32'h0);
      check("rst_xy", {11'b0, ifc.e_XY0_br}, 32'h0);
      check("rst_active", {31'b0, br_active}, 32'h0);
      check("rst_hit", {31'b0, hit_qb}, 32'h0);
      reset = 1'b1;
      chk_on = 1'b1;

      repeat (100) tick();
      check("idle_position", position_br, 32'h0);
      check("idle_enable", {31'b0, ifc.e_enable_br}, 32'h0);

      // First launch: latency, pattern and side from the seed.
      qpos = 32'h8;
      start = 1'b1; tick(); start = 1'b0;
      wait_launch(k);
      check("launch_latency", k, 32'd5);
      check("launch_move", {25'b0, ifc.e_move_br}, 32'h4E);
      check("launch_xy", {11'b0, ifc.e_XY0_br}, {11'b0, XY2});
      hop(); check("hop0_pos", position_br, lit1[0]);
      hop(); check("hop1_pos", position_br, lit1[1]);
`ifdef BOULE_ROUGE_HIT_EN
      check("hit_once", hit_cnt, 32'd1);
`endif

      // Pause mid-flight: hops ignored until resume.
      pause = 1'b1; tick(); pause = 1'b0;
      repeat (3) begin
         ifc.done_move = 1'b1; tick();
         ifc.done_move = 1'b0; tick();
      end
      check("paused_pos", position_br, 32'h8);
      check("paused_active", {31'b0, br_active}, 32'h1);
      resume = 1'b1; tick(); resume = 1'b0; tick();
      for (int i = 2; i < 6; i++) begin
         hop();
         check("resumed_pos", position_br, lit1[i]);
      end
      hop();
      check("end_pos", position_br, 32'h0);
      check("end_active", {31'b0, br_active}, 32'h0);

      // Second launch killed by the saucer strobe.
      wait_launch(k);
      check("launch2_seen", {31'b0, k != 0}, 32'h1);
      repeat (3) hop();
      ifc.done_move_sc = 1'b1; tick(); ifc.done_move_sc = 1'b0;
      check("sc_pos", position_br, 32'h0);
      check("sc_active", {31'b0, br_active}, 32'h0);

      // Third launch restarted, then a pause during the spawn wait.
      wait_launch(k);
      check("launch3_seen", {31'b0, k != 0}, 32'h1);
      hop();
      start = 1'b1; tick(); start = 1'b0;
      check("restart_pos", position_br, 32'h0);
      pause = 1'b1; tick(); pause = 1'b0;
      repeat (3) tick();
      resume = 1'b1; tick(); resume = 1'b0;
      wait_launch(k);
      check("launch4_seen", {31'b0, k != 0}, 32'h1);
      repeat (7) hop();
      check("final_pos", position_br, 32'h0);
      repeat (3) tick();

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
